// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: columns are written into one bank while the
// other bank is read back out as rows.
module dct_transpose_buf #(
    parameter int SIZE = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [7:0][SIZE-1:0] data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [7:0][SIZE-1:0] data_out,
    output logic                        out_first,
    output logic                        out_last
);

    logic [SIZE-1:0] mem_r [2][8][8];  // [bank][row][col]
    logic [1:0]      full_r;
    logic            wb_r;
    logic            rb_r;
    logic [2:0]      wc_r;
    logic [2:0]      rc_r;

    logic            wr_fire_s;
    logic            rd_fire_s;
    logic            wr_last_s;
    logic            rd_last_s;
    logic [1:0]      full_set_s;
    logic [1:0]      full_clr_s;
    logic [1:0]      full_nxt_s;

    // Handshake status is decoded from flops only, never from the peer's valid/ready.
    assign in_ready  = ~full_r[wb_r];
    assign out_valid = full_r[rb_r];
    assign out_first = (rc_r == 3'd0);
    assign out_last  = (rc_r == 3'd7);

    assign wr_fire_s = in_valid & ~full_r[wb_r];
    assign rd_fire_s = out_ready & full_r[rb_r];
    assign wr_last_s = wr_fire_s & (wc_r == 3'd7);
    assign rd_last_s = rd_fire_s & (rc_r == 3'd7);

    // The write bank is never full and the read bank always is, so set and clear
    // can never target the same bank on one edge.
    assign full_set_s = wr_last_s ? (2'b01 << wb_r) : 2'b00;
    assign full_clr_s = rd_last_s ? (2'b01 << rb_r) : 2'b00;
    assign full_nxt_s = (full_r | full_set_s) & ~full_clr_s;

    // Bank/column/row pointers and bank full flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r <= 2'b00;
            wb_r   <= 1'b0;
            rb_r   <= 1'b0;
            wc_r   <= 3'd0;
            rc_r   <= 3'd0;
        end else begin
            full_r <= full_nxt_s;
            wb_r   <= wb_r ^ wr_last_s;
            rb_r   <= rb_r ^ rd_last_s;
            if (wr_fire_s) begin
                wc_r <= wc_r + 3'd1;
            end
            if (rd_fire_s) begin
                rc_r <= rc_r + 3'd1;
            end
        end
    end

    // Coefficient storage: an accepted column lands in column wc of the write bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        mem_r[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_fire_s) begin
            for (int r = 0; r < 8; r++) begin
                mem_r[wb_r][r][wc_r] <= data_in[r];
            end
        end
    end

    // Row read mux straight off the storage registers.
    always_comb begin
        data_out = '0;
        for (int c = 0; c < 8; c++) begin
            data_out[c] = mem_r[rb_r][rc_r][c];
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: expected rows are queued when a
// block's columns are generated and compared as the DUT emits rows.
module tb_dct_transpose_buf;

    localparam int SIZE = 16;

    typedef struct packed {
        logic                 first;
        logic                 last;
        logic [7:0][SIZE-1:0] data;
    } row_t;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic [7:0][SIZE-1:0] data_in   = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_first;
    logic                 out_last;
    logic [7:0][SIZE-1:0] data_out;

    int total = 0;
    int bad = 0;
    int wcol = 0;
    int blocks_pending = 0;
    int blk_kind = 0;
    int acc_cnt = 0;
    logic [SIZE-1:0] src [8][8];  // [col][row]
    row_t exp_q[$];
    row_t e;

    dct_transpose_buf #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Generate the next source block and queue its transposed rows.
    function automatic void start_block();
        row_t row;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                case (blk_kind)
                    0: src[c][r] = 16'(16 * c + r);
                    1: src[c][r] = (c == 0) ? 16'h8000 : ((c == 7) ? 16'h7FFF : 16'hFFFF);
                    default: src[c][r] = 16'($urandom);
                endcase
            end
        end
        for (int r = 0; r < 8; r++) begin
            row.first = (r == 0);
            row.last  = (r == 7);
            for (int c = 0; c < 8; c++) row.data[c] = src[c][r];
            exp_q.push_back(row);
        end
        wcol = 0;
    endfunction

    task automatic set_inputs();
        in_valid = (blocks_pending > 0);
        for (int r = 0; r < 8; r++) data_in[r] = src[wcol][r];
    endtask

    // Book-keep a column accepted at the coming edge.
    function automatic void advance();
        if (in_valid && in_ready) begin
            acc_cnt++;
            wcol++;
            if (wcol == 8) begin
                wcol = 0;
                blocks_pending--;
                if (blocks_pending > 0) start_block();
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_first !== 1'b1) begin bad++; $display("FAIL reset_out_first: got %b want 1", out_first); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        total++; if (data_out !== '0) begin bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_block(input int kind, input string name);
        blk_kind = kind; blocks_pending = 1; start_block();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            set_inputs();
            out_ready = 1'b1;
            total++;
            if (out_valid !== (i >= 8 && i <= 15)) begin
                bad++; $display("FAIL %s_valid cycle %0d: got %b want %b", name, i, out_valid, (i >= 8 && i <= 15));
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL %s_row: got extra row %h want none", name, data_out); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_first, out_last, data_out} !== {e.first, e.last, e.data}) begin
                        bad++; $display("FAIL %s_row: got f%b l%b %h want f%b l%b %h", name, out_first, out_last, data_out, e.first, e.last, e.data);
                    end
                end
            end
            advance();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL %s_left: got %0d rows pending want 0", name, exp_q.size()); end
    endtask

    task automatic test_back_pressure();
        int guard;
        blk_kind = 2; blocks_pending = 3; acc_cnt = 0; start_block();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_inputs();
            out_ready = 1'b0;
            total++;
            if (in_ready !== (acc_cnt < 16)) begin bad++; $display("FAIL bp_in_ready cycle %0d: got %b want %b", i, in_ready, (acc_cnt < 16)); end
            advance();
        end
        total++; if (acc_cnt != 16) begin bad++; $display("FAIL bp_accepted: got %0d want 16", acc_cnt); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_inputs();
            out_ready = 1'b1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_drain_in_ready row %0d: got %b want 0", i, in_ready); end
            total++;
            if (!out_valid) begin bad++; $display("FAIL bp_drain_valid row %0d: got 0 want 1", i); end
            else begin
                e = exp_q.pop_front();
                if ({out_first, out_last, data_out} !== {e.first, e.last, e.data}) begin
                    bad++; $display("FAIL bp_row: got f%b l%b %h want f%b l%b %h", out_first, out_last, data_out, e.first, e.last, e.data);
                end
            end
            advance();
        end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_restore: got %b want 1", in_ready); end
        guard = 0;
        while ((exp_q.size() != 0 || blocks_pending != 0) && guard < 200) begin
            set_inputs();
            out_ready = 1'b1;
            if (out_valid) begin
                total++;
                e = exp_q.pop_front();
                if ({out_first, out_last, data_out} !== {e.first, e.last, e.data}) begin
                    bad++; $display("FAIL bp_tail_row: got f%b l%b %h want f%b l%b %h", out_first, out_last, data_out, e.first, e.last, e.data);
                end
            end
            advance();
            guard++;
            @(negedge clk);
        end
        total++; if (guard >= 200) begin bad++; $display("FAIL bp_timeout: got %0d cycles want < 200", guard); end
    endtask

    task automatic test_streaming();
        int guard;
        int drops;
        blk_kind = 2; blocks_pending = 4; start_block();
        guard = 0; drops = 0;
        while ((exp_q.size() != 0 || blocks_pending != 0) && guard < 200) begin
            @(negedge clk);
            set_inputs();
            out_ready = 1'b1;
            if (blocks_pending > 0 && in_ready !== 1'b1) drops++;
            if (out_valid) begin
                total++;
                e = exp_q.pop_front();
                if ({out_first, out_last, data_out} !== {e.first, e.last, e.data}) begin
                    bad++; $display("FAIL stream_row: got f%b l%b %h want f%b l%b %h", out_first, out_last, data_out, e.first, e.last, e.data);
                end
            end
            advance();
            guard++;
        end
        total++; if (drops != 0) begin bad++; $display("FAIL stream_in_ready: got %0d stalled cycles want 0", drops); end
        total++; if (guard != 40) begin bad++; $display("FAIL stream_cycles: got %0d want 40", guard); end
    endtask

    task automatic test_stall_mid_drain();
        int guard;
        int rows;
        int stall;
        blk_kind = 2; blocks_pending = 1; start_block();
        guard = 0; rows = 0; stall = 0;
        while ((exp_q.size() != 0 || blocks_pending != 0) && guard < 100) begin
            @(negedge clk);
            set_inputs();
            out_ready = !(rows == 4 && stall < 5);
            if (!out_ready) begin
                stall++;
                total++;
                if ({out_valid, out_first, out_last, data_out} !== {1'b1, 1'b0, 1'b0, exp_q[0].data}) begin
                    bad++; $display("FAIL stall_hold: got v%b f%b l%b %h want v1 f0 l0 %h", out_valid, out_first, out_last, data_out, exp_q[0].data);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                rows++;
                e = exp_q.pop_front();
                if ({out_first, out_last, data_out} !== {e.first, e.last, e.data}) begin
                    bad++; $display("FAIL stall_row %0d: got f%b l%b %h want f%b l%b %h", rows - 1, out_first, out_last, data_out, e.first, e.last, e.data);
                end
            end
            advance();
            guard++;
        end
        total++; if (stall != 5 || rows != 8) begin bad++; $display("FAIL stall_count: got stall=%0d rows=%0d want 5 and 8", stall, rows); end
    endtask

    task automatic test_reset_mid_fill();
        int guard;
        blk_kind = 2; blocks_pending = 1; acc_cnt = 0; start_block();
        while (acc_cnt < 5) begin
            @(negedge clk);
            set_inputs();
            out_ready = 1'b1;
            advance();
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({out_valid, in_ready, out_first} !== 3'b011) begin bad++; $display("FAIL rst_mid_outputs: got v%b r%b f%b want v0 r1 f1", out_valid, in_ready, out_first); end
        exp_q.delete();
        blocks_pending = 0; wcol = 0;
        @(negedge clk);
        rst_n = 1'b1;
        blk_kind = 0; blocks_pending = 1; start_block();
        guard = 0;
        while (guard < 24) begin
            @(negedge clk);
            set_inputs();
            out_ready = 1'b1;
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rst_fresh_row: got extra row %h want none", data_out); end
                else begin
                    e = exp_q.pop_front();
                    if ({out_first, out_last, data_out} !== {e.first, e.last, e.data}) begin
                        bad++; $display("FAIL rst_fresh_row: got f%b l%b %h want f%b l%b %h", out_first, out_last, data_out, e.first, e.last, e.data);
                    end
                end
            end
            advance();
            guard++;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst_fresh_left: got %0d rows pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_block(0, "single");
        test_back_pressure();
        test_streaming();
        test_single_block(1, "signed");
        test_stall_mid_drain();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
Ping-pong 8x8 transpose buffer between the column-wise DCT pass and the row-wise pass. It accepts one 8-element column vector per handshake, for example the output of the stage-2 column register. After 8 columns it presents the block back as 8 row vectors. Two banks allow full-rate streaming: one bank fills while the other drains.

Parameters:
SIZE, 16, signed width of each coefficient, bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  data_in holds a valid column
in_ready  output  1  buffer can accept a column this cycle
data_in  input  SIZE x [7:0] signed  column vector; index = row
out_valid  output  1  data_out holds a valid row
out_ready  input  1  downstream accepts a row this cycle
data_out  output  SIZE x [7:0] signed  row vector; index = column
out_first  output  1  data_out is row 0 of a block
out_last  output  1  data_out is row 7 of a block

Behaviour:
- Storage: two banks, each 8x8 x SIZE. State per bank: full flag.
- Pointers: write bank wb and write column wc (0..7); read bank rb and read row rc (0..7).
- Reset (rst=0, asynchronous): wb=rb=0, wc=rc=0, both full flags 0, all storage 0. Resulting outputs: in_ready=1, out_valid=0, out_first=1, out_last=0, data_out=0.
- Write:
  - in_ready = !full[wb], combinational from flops only; no dependence on in_valid or out_ready.
  - Accept when in_valid && in_ready: bank[wb][r][wc] <= data_in[r] for r=0..7, then wc++.
  - Accept with wc==7: full[wb]<=1, wb toggles, wc<=0.
  - in_valid while in_ready=0: data is ignored; the upstream source holds it.
- Read:
  - out_valid = full[rb].
  - data_out[c] = bank[rb][rc][c], a mux driven from registers only.
  - out_first = (rc==0); out_last = (rc==7).
  - Transfer when out_valid && out_ready: rc++.
  - Transfer with rc==7: full[rb]<=0, rb toggles, rc<=0.
- Timing:
  - Latency: the 8th column is accepted at edge N; out_valid=1 after edge N, so row 0 is visible in the cycle following edge N.
  - With out_ready held high, steady state is 1 column in and 1 row out per cycle. in_ready never drops.
- Simultaneous events:
  - Writing the last column of bank A and draining the last row of bank B on the same edge is legal. Both flags update independently.
  - A bank is never written and read at the same time, because the write bank is never full and the read bank is always full.
- Boundaries:
  - Both banks full: in_ready=0 until the read side completes row 7.
  - Pointers wrap mod 8; bank pointers toggle mod 2.
- Arithmetic: none. Values pass bit-exact, sign preserved, no saturation.
- Reset mid-operation: a partial block is discarded, and any block being drained is dropped. Outputs return to reset values asynchronously.
- Outputs are stable while out_valid=1 && out_ready=0.

Test Plan:
- Single block transpose: reset, feed 8 columns with data_in[r] = 16*c + r (c=0..7), out_ready=1. Required: out_valid rises the cycle after column 7 is accepted; row r gives data_out[c] = 16*c + r. out_first is set on row 0 only, out_last on row 7 only.
- Back-pressure: out_ready=0, feed columns continuously. Required: in_ready=1 through 16 accepted columns, then 0. The 17th column is not accepted. Raising out_ready for 8 cycles drains block 0 and restores in_ready=1.
- Streaming: 4 blocks back-to-back with in_valid=1 and out_ready=1. Required: in_ready is never 0, rows appear in block order, and every output is correctly transposed.
- Signed extremes: SIZE=16, column 0 all -32768, column 7 all 32767, others -1. Required: every row reads [-32768, -1, -1, -1, -1, -1, -1, 32767] exactly.
- Stall mid-drain: after row 3 is emitted, drop out_ready for 5 cycles. Required: data_out stays equal to row 4 and out_valid stays 1; the sequence then resumes at row 4.
- Reset mid-fill: accept 5 columns, assert rst for 1 cycle, then feed a fresh block. Required: out_valid=0 immediately on reset, and output contains only the fresh block's data.
